// File: rtl/yarvis_spi_pkg.sv
// Shared opcodes, frame constants and FSM state encoding for the yarvis SPI RAM initiator.
package yarvis_spi_pkg;

  localparam int         CMD_BITS  = 8;
  localparam logic [7:0] OPC_READ  = 8'h03;
  localparam logic [7:0] OPC_WRITE = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DONE
  } state_t;

endpackage

// File: rtl/yarvis_spi_shreg.sv
// Loadable frame shift register: MSB drives mosi, miso enters at the LSB.
// Single-cycle load/shift; no backpressure, the parent sequences every shift.
module yarvis_spi_shreg #(
  parameter int W    = 64,
  parameter int RX_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [W-1:0]    load_dat,
  input  logic            shift,
  input  logic            shift_in,
  output logic            msb_dat,
  output logic [RX_W-1:0] rx_nxt_dat
);

  logic [W-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_dat;
    end else if (shift) begin
      q <= {q[W-2:0], shift_in};
    end
  end

  assign msb_dat = q[W-1];
  // Receive word as it will look after the pending shift; lets the final bit be captured on the same edge.
  assign rx_nxt_dat = {q[RX_W-2:0], shift_in};

endmodule

// File: rtl/yarvis_spi_mem_master.sv
// SPI mode-0 initiator moving one DATA_W word per frame to/from an external SPI RAM.
// Response 2N+1 cycles after accept; req_ready low for the whole frame including DONE.
module yarvis_spi_mem_master
  import yarvis_spi_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 32,
  parameter int DUMMY_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int FRAME_W = CMD_BITS + ADDR_W + DATA_W;
  localparam int LEN_AD  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int LEN_ADC = (LEN_AD > CMD_BITS) ? LEN_AD : CMD_BITS;
  localparam int MAX_LEN = (LEN_ADC > DUMMY_CYCLES) ? LEN_ADC : DUMMY_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  state_t              state_q, state_d;
  logic                sclk_q, sclk_d;
  logic                miso_q, miso_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                sh_load, sh_shift, rdata_ld, seg_last, in_frame, sh_msb;
  int                  seg_len;
  logic [DATA_W-1:0]   wdata_sw, rx_nxt, rx_sw;
  logic [FRAME_W-1:0]  load_dat;

  // Little-endian on the wire: byte 0 occupies the top of the shift word so it leaves first.
  always_comb begin
    wdata_sw = '0;
    rx_sw    = '0;
    for (int i = 0; i < DATA_W / 8; i++) begin
      wdata_sw[DATA_W-1-8*i -: 8] = req_wdata[8*i +: 8];
      rx_sw[8*i +: 8]             = rx_nxt[DATA_W-1-8*i -: 8];
    end
  end

  assign load_dat = {(req_we ? OPC_WRITE : OPC_READ), req_addr, (req_we ? wdata_sw : '0)};

  yarvis_spi_shreg #(.W(FRAME_W), .RX_W(DATA_W)) u_shreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (sh_load),
    .load_dat   (load_dat),
    .shift      (sh_shift),
    .shift_in   (miso_q),
    .msb_dat    (sh_msb),
    .rx_nxt_dat (rx_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sclk_q  <= 1'b0;
      miso_q  <= 1'b0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sclk_q  <= sclk_d;
      miso_q  <= miso_d;
      cnt_q   <= cnt_d;
      if (sh_load) we_q <= req_we;
      if (rdata_ld) rdata_q <= rx_sw;
    end
  end

  always_comb begin
    state_d  = state_q;
    sclk_d   = 1'b0;
    miso_d   = miso_q;
    cnt_d    = cnt_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    rdata_ld = 1'b0;
    case (state_q)
      ST_CMD:   seg_len = CMD_BITS;
      ST_ADDR:  seg_len = ADDR_W;
      ST_DUMMY: seg_len = DUMMY_CYCLES;
      ST_DATA:  seg_len = DATA_W;
      default:  seg_len = 1;
    endcase
    seg_last = (cnt_q == CNT_W'(seg_len - 1));

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          sh_load = 1'b1;
          cnt_d   = '0;
          state_d = ST_CMD;
        end
      end
      ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
        if (!sclk_q) begin
          sclk_d = 1'b1;
          miso_d = spi_miso;
        end else begin
          // Shift on the falling edge so mosi only moves while sclk is low.
          sh_shift = (state_q != ST_DUMMY);
          cnt_d    = seg_last ? '0 : cnt_q + 1'b1;
          if (seg_last) begin
            case (state_q)
              ST_CMD:   state_d = ST_ADDR;
              ST_ADDR:  state_d = (!we_q && DUMMY_CYCLES > 0) ? ST_DUMMY : ST_DATA;
              ST_DUMMY: state_d = ST_DATA;
              default: begin
                state_d  = ST_DONE;
                rdata_ld = !we_q;
              end
            endcase
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign in_frame  = state_q inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA};
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_rdata = rdata_q;
  assign spi_cs_n  = !in_frame;
  assign spi_sclk  = in_frame && sclk_q;
  assign spi_mosi  = in_frame && (state_q != ST_DUMMY) && sh_msb;

endmodule

// File: tb/tb_yarvis_spi_mem_master.sv
// Scoreboard bench: SPI RAM model per DUT instance, expected responses queued at issue time.
module tb_yarvis_spi_mem_master;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];

  logic        req_valid0, req_ready0, req_we0, rsp_valid0, cs_n0, sclk0, mosi0, miso0;
  logic [23:0] req_addr0;
  logic [31:0] req_wdata0, rsp_rdata0;
  logic        req_valid1, req_ready1, req_we1, rsp_valid1, cs_n1, sclk1, mosi1, miso1;
  logic [23:0] req_addr1;
  logic [31:0] req_wdata1, rsp_rdata1;

  logic [7:0]   ram0[4], ram1[4];
  int           sck0 = 0, sck1 = 0;
  logic [127:0] cap0 = '0, cap1 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  yarvis_spi_mem_master #(.ADDR_W(24), .DATA_W(32), .DUMMY_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
    .spi_cs_n(cs_n0), .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_miso(miso0)
  );

  yarvis_spi_mem_master #(.ADDR_W(24), .DATA_W(32), .DUMMY_CYCLES(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
    .spi_cs_n(cs_n1), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso1)
  );

  // RAM model: bit k of the frame is presented before rising edge k; ones outside the data phase.
  function automatic logic miso_fn(int k, int d, int sel);
    int j;
    logic [7:0] b;
    j = k - 32 - d;
    if (j < 0 || j >= 32) return 1'b1;
    b = (sel == 0) ? ram0[j / 8] : ram1[j / 8];
    return b[7 - (j % 8)];
  endfunction

  always @(negedge cs_n0) begin sck0 = 0; cap0 = '0; miso0 = miso_fn(0, 0, 0); end
  always @(posedge sclk0) if (!cs_n0) begin
    cap0 = {cap0[126:0], mosi0}; sck0++; miso0 = miso_fn(sck0, 0, 0);
  end
  always @(negedge cs_n1) begin sck1 = 0; cap1 = '0; miso1 = miso_fn(0, 8, 1); end
  always @(posedge sclk1) if (!cs_n1) begin
    cap1 = {cap1[126:0], mosi1}; sck1++; miso1 = miso_fn(sck1, 8, 1);
  end

  task automatic issue(input int sel, input logic we, input logic [23:0] a, input logic [31:0] wd,
                       input bit hold, output int acc, output bit ok);
    ok = 1'b0;
    acc = 0;
    @(negedge clk);
    if (sel == 0) begin req_we0 = we; req_addr0 = a; req_wdata0 = wd; req_valid0 = 1'b1; end
    else          begin req_we1 = we; req_addr1 = a; req_wdata1 = wd; req_valid1 = 1'b1; end
    for (int i = 0; i < 300 && !ok; i++) begin
      if (((sel == 0) ? req_ready0 : req_ready1) === 1'b1) begin acc = cyc; ok = 1'b1; end
      @(negedge clk);
    end
    if (!hold) begin req_valid0 = 1'b0; req_valid1 = 1'b0; end
  endtask

  task automatic wait_rsp(input int sel, input int acc, output int lat, output logic [31:0] rd,
                          output bit ok);
    ok = 1'b0;
    lat = -1;
    rd = '0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (((sel == 0) ? rsp_valid0 : rsp_valid1) === 1'b1) begin
        lat = cyc - acc; rd = (sel == 0) ? rsp_rdata0 : rsp_rdata1; ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (cs_n0 !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n got=%b want=1", cs_n0); end
    n_cmp++; if (sclk0 !== 1'b0) begin n_bad++; $display("FAIL reset_sclk got=%b want=0", sclk0); end
    n_cmp++; if (mosi0 !== 1'b0) begin n_bad++; $display("FAIL reset_mosi got=%b want=0", mosi0); end
    n_cmp++; if (rsp_valid0 !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid0); end
    n_cmp++; if (req_ready0 !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready0); end
    n_cmp++; if (rsp_rdata0 !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata0); end
    n_cmp++; if (cs_n1 !== 1'b1 || req_ready1 !== 1'b1) begin
      n_bad++; $display("FAIL reset_dummy_inst got cs_n=%b ready=%b want 1/1", cs_n1, req_ready1);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    exp_t e; int acc, lat; logic [31:0] rd; bit ok;
    ram0[0] = 8'h11; ram0[1] = 8'h22; ram0[2] = 8'h33; ram0[3] = 8'h44;
    sb.push_back('{rdata: 32'h44332211, lat: 129});
    issue(0, 1'b0, 24'h000010, 32'h0, 1'b0, acc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL read_accept got=timeout want=accept"); end
    wait_rsp(0, acc, lat, rd, ok);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL read_latency got=%0d want=%0d", lat, e.lat); end
    n_cmp++; if (rd !== e.rdata) begin n_bad++; $display("FAIL read_rdata got=%h want=%h", rd, e.rdata); end
    n_cmp++; if (cap0[63:32] !== 32'h03000010) begin
      n_bad++; $display("FAIL read_mosi_hdr got=%h want=03000010", cap0[63:32]);
    end
    n_cmp++; if (sck0 !== 64) begin n_bad++; $display("FAIL read_sclk_edges got=%0d want=64", sck0); end
    @(negedge clk);
    n_cmp++; if (req_ready0 !== 1'b1) begin n_bad++; $display("FAIL read_ready_after got=%b want=1", req_ready0); end
  endtask

  task automatic test_write();
    exp_t e; int acc, lat; logic [31:0] rd; bit ok;
    sb.push_back('{rdata: 32'h44332211, lat: 129});
    issue(0, 1'b1, 24'h0000FC, 32'hDEADBEEF, 1'b0, acc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL write_accept got=timeout want=accept"); end
    wait_rsp(0, acc, lat, rd, ok);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL write_latency got=%0d want=%0d", lat, e.lat); end
    n_cmp++; if (rd !== e.rdata) begin n_bad++; $display("FAIL write_rdata_kept got=%h want=%h", rd, e.rdata); end
    n_cmp++; if (cap0[63:0] !== 64'h020000FC_EFBEADDE) begin
      n_bad++; $display("FAIL write_mosi got=%h want=020000fcefbeadde", cap0[63:0]);
    end
    n_cmp++; if (sck0 !== 64) begin n_bad++; $display("FAIL write_sclk_edges got=%0d want=64", sck0); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e; int acc, rel, lat, rdy_bad; logic [31:0] rd, rd1; bit ok;
    logic cs128, cs129, cs131, rv128, rv129, rdy130;
    ram0[0] = 8'h55; ram0[1] = 8'h66; ram0[2] = 8'h77; ram0[3] = 8'h88;
    sb.push_back('{rdata: 32'h88776655, lat: 129});
    sb.push_back('{rdata: 32'h88776655, lat: 129});
    rdy_bad = 0; cs128 = 1'bx; cs129 = 1'bx; cs131 = 1'bx; rv128 = 1'bx; rv129 = 1'bx; rdy130 = 1'bx; rd1 = '0;
    issue(0, 1'b0, 24'h000040, 32'h0, 1'b1, acc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_accept got=timeout want=accept"); end
    for (int i = 0; i < 131; i++) begin
      rel = cyc - acc;
      if (rel <= 129 && req_ready0 !== 1'b0) rdy_bad++;
      if (rel == 128) begin cs128 = cs_n0; rv128 = rsp_valid0; end
      if (rel == 129) begin cs129 = cs_n0; rv129 = rsp_valid0; rd1 = rsp_rdata0; end
      if (rel == 130) rdy130 = req_ready0;
      if (rel == 131) begin cs131 = cs_n0; req_valid0 = 1'b0; end
      @(negedge clk);
    end
    e = sb.pop_front();
    n_cmp++; if (rv128 !== 1'b0 || rv129 !== 1'b1) begin
      n_bad++; $display("FAIL b2b_rsp1_timing got rv128=%b rv129=%b want 0/1 (lat %0d)", rv128, rv129, e.lat);
    end
    n_cmp++; if (rd1 !== e.rdata) begin n_bad++; $display("FAIL b2b_rdata1 got=%h want=%h", rd1, e.rdata); end
    n_cmp++; if (rdy_bad !== 0) begin n_bad++; $display("FAIL b2b_ready_low got=%0d high cycles want=0", rdy_bad); end
    n_cmp++; if (rdy130 !== 1'b1) begin n_bad++; $display("FAIL b2b_ready130 got=%b want=1", rdy130); end
    n_cmp++; if (cs128 !== 1'b0 || cs129 !== 1'b1 || cs131 !== 1'b0) begin
      n_bad++; $display("FAIL b2b_cs_gap got=%b%b%b want=010", cs128, cs129, cs131);
    end
    wait_rsp(0, acc + 130, lat, rd, ok);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL b2b_latency2 got=%0d want=%0d", lat, e.lat); end
    n_cmp++; if (rd !== e.rdata) begin n_bad++; $display("FAIL b2b_rdata2 got=%h want=%h", rd, e.rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    exp_t e; int acc, lat; logic [31:0] rd; bit ok, rsp_seen;
    rsp_seen = 1'b0;
    issue(0, 1'b1, 24'h000100, 32'h12345678, 1'b0, acc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_mid_accept got=timeout want=accept"); end
    for (int i = 0; i < 60 && (cyc - acc) < 40; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cs_n0 !== 1'b1 || sclk0 !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_pins got cs_n=%b sclk=%b want 1/0", cs_n0, sclk0);
    end
    repeat (3) begin @(negedge clk); if (rsp_valid0 !== 1'b0) rsp_seen = 1'b1; end
    rst_n = 1'b1;
    repeat (150) begin @(negedge clk); if (rsp_valid0 !== 1'b0) rsp_seen = 1'b1; end
    n_cmp++; if (rsp_seen !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_rsp got=%b want=0", rsp_seen); end
    n_cmp++; if (req_ready0 !== 1'b1 || rsp_rdata0 !== 32'h0) begin
      n_bad++; $display("FAIL rst_mid_idle got ready=%b rdata=%h want 1/0", req_ready0, rsp_rdata0);
    end
    sb.push_back('{rdata: 32'h0, lat: 129});
    issue(0, 1'b1, 24'h000200, 32'hCAFEF00D, 1'b0, acc, ok);
    wait_rsp(0, acc, lat, rd, ok);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat || rd !== e.rdata) begin
      n_bad++; $display("FAIL rst_mid_refrm got lat=%0d rdata=%h want %0d/%h", lat, rd, e.lat, e.rdata);
    end
    n_cmp++; if (cap0[63:0] !== 64'h02000200_0DF0FECA || sck0 !== 64) begin
      n_bad++; $display("FAIL rst_mid_refrm_mosi got=%h edges=%0d want=020002000df0feca/64", cap0[63:0], sck0);
    end
    @(negedge clk);
  endtask

  task automatic test_dummy();
    exp_t e; int acc, lat; logic [31:0] rd; bit ok;
    ram1[0] = 8'hA1; ram1[1] = 8'hB2; ram1[2] = 8'hC3; ram1[3] = 8'hD4;
    sb.push_back('{rdata: 32'hD4C3B2A1, lat: 145});
    issue(1, 1'b0, 24'h000020, 32'h0, 1'b0, acc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL dummy_accept got=timeout want=accept"); end
    wait_rsp(1, acc, lat, rd, ok);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL dummy_latency got=%0d want=%0d", lat, e.lat); end
    n_cmp++; if (rd !== e.rdata) begin n_bad++; $display("FAIL dummy_rdata got=%h want=%h", rd, e.rdata); end
    n_cmp++; if (cap1[71:40] !== 32'h03000020 || cap1[39:32] !== 8'h00) begin
      n_bad++; $display("FAIL dummy_mosi got=%h/%h want=03000020/00", cap1[71:40], cap1[39:32]);
    end
    n_cmp++; if (sck1 !== 72) begin n_bad++; $display("FAIL dummy_sclk_edges got=%0d want=72", sck1); end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; miso0 = 1'b0;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; miso1 = 1'b0;
    for (int i = 0; i < 4; i++) begin ram0[i] = 8'h00; ram1[i] = 8'h00; end
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_mid_write();
    test_dummy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=time limit reached want=bench completion");
    $fatal(1, "watchdog");
  end

endmodule
